mem36_avs: RTL

Avalon-MM slave memory for 36-bit PDP-6 words, sitting directly downstream of the 32K core memory module's Avalon master port (`m_address`/`m_read`/`m_write`/`m_writedata`/`m_readdata`/`m_waitrequest`).
- Stores words in an on-chip synchronous RAM and answers each transfer after a programmable number of wait cycles, mimicking core access time.
- Flags accesses beyond the implemented depth.
- Optionally keeps a per-word parity bit and reports parity errors.

---
 rtl/mem36_pkg.sv | 14 +
 rtl/mem36_ram.sv | 21 ++
 rtl/mem36_avs.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem36_pkg.sv
// Shared types and constants for the mem36 Avalon-MM memory slice.
package mem36_pkg;

  localparam int WORD_W = 36;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mem36_ram.sv
// Single-port synchronous RAM with registered read data, block-RAM inferable.
module mem36_ram #(
  parameter int WIDTH = 36,
  parameter int AW    = 15
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem36_avs.sv
// Avalon-MM slave memory for 36-bit PDP-6 words with programmable access delay.
// Optional per-word parity: define MEM36_PARITY_EN.
module mem36_avs
  import mem36_pkg::*;
#(
  parameter int ADDR_WIDTH  = 15,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [17:0]       s_address,
  input  logic              s_read,
  input  logic              s_write,
  input  logic [WORD_W-1:0] s_writedata,
  output logic [WORD_W-1:0] s_readdata,
  output logic              s_waitrequest,
  input  logic              parity_inject,
  output logic              oob_err,
  output logic              parity_err
);

`ifdef MEM36_PARITY_EN
  localparam int RAM_W = WORD_W + 1;
`else
  localparam int RAM_W = WORD_W;
`endif

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [WORD_W-1:0]       data_q;
  logic                    wr_q;
  logic                    oob_q;
  logic                    inj_q;

  logic                    req;
  logic                    addr_oob;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic                    ram_we;
  logic [RAM_W-1:0]        ram_wdata;
  logic [RAM_W-1:0]        ram_q;
  logic                    par_bad;

  assign req      = s_read | s_write;
  assign addr_oob = (s_address >> ADDR_WIDTH) != '0;
  // The RAM sees the live address while idle so the read word is already
  // registered by the time ACCESS runs, even with zero wait cycles.
  assign ram_addr = (state == IDLE) ? s_address[ADDR_WIDTH-1:0] : addr_q;
  assign ram_we   = (state == ACCESS) && wr_q && !oob_q;

`ifdef MEM36_PARITY_EN
  assign ram_wdata = {(^data_q) ^ inj_q, data_q};
  assign par_bad   = ^ram_q;
`else
  logic unused_par;
  assign ram_wdata  = data_q;
  assign par_bad    = 1'b0;
  assign unused_par = inj_q ^ parity_inject;
`endif

  mem36_ram #(
    .WIDTH (RAM_W),
    .AW    (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      wr_q          <= 1'b0;
      oob_q         <= 1'b0;
      inj_q         <= 1'b0;
      s_readdata    <= '0;
      s_waitrequest <= 1'b1;
      oob_err       <= 1'b0;
      parity_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q <= s_address[ADDR_WIDTH-1:0];
            data_q <= s_writedata;
            wr_q   <= s_write;
            oob_q  <= addr_oob;
            inj_q  <= parity_inject;
            if (addr_oob || (s_read && s_write))
              oob_err <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= ACCESS;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1))
            state <= ACCESS;
        end
        ACCESS: begin
          state         <= DONE;
          s_waitrequest <= 1'b0;
          if (!wr_q) begin
            if (oob_q) begin
              s_readdata <= '0;
            end else begin
              s_readdata <= ram_q[WORD_W-1:0];
              if (par_bad)
                parity_err <= 1'b1;
            end
          end
        end
        DONE: begin
          s_waitrequest <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
